// File: rtl/pwm_duty_ramp_sequencer.sv
// Purpose: ramps the PWM duty value toward a latched target in clamped steps at a set interval.
// Latency: first step lands step_interval edges after an accepted start; all outputs registered.
// Backpressure: none; start is dropped while busy, abort ends a ramp and holds the duty value.
module pwm_duty_ramp_sequencer #(
    parameter int DUTY_W = 8,
    parameter int IVL_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [DUTY_W-1:0] step_size,
    input  logic [IVL_W-1:0]  step_interval,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done,
    output logic              dir_up
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_d, tgt_q, tgt_d, step_q, step_d;
    logic [IVL_W-1:0]  ivl_q, ivl_d, cnt_q, cnt_d;
    logic              busy_d, done_d, dir_d;
    logic [DUTY_W-1:0] step_eff, step_res;
    logic [IVL_W-1:0]  ivl_eff;
    logic [DUTY_W:0]   up_sum, dn_diff;

    // Zero step/interval are stored as 1 so the ramp logic never sees them.
    assign step_eff = (step_size == '0) ? DUTY_W'(1) : step_size;
    assign ivl_eff  = (step_interval == '0) ? IVL_W'(1) : step_interval;

    // One extra bit keeps the sum/difference from wrapping before the clamp.
    assign up_sum  = {1'b0, duty_out} + {1'b0, step_q};
    assign dn_diff = {1'b0, duty_out} - {1'b0, step_q};

    always_comb begin
        step_res = duty_out;
        if (dir_up) begin
            step_res = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[DUTY_W-1:0];
        end else if (duty_out < step_q) begin
            step_res = tgt_q;
        end else begin
            step_res = (dn_diff < {1'b0, tgt_q}) ? tgt_q : dn_diff[DUTY_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_out;
        tgt_d   = tgt_q;
        step_d  = step_q;
        ivl_d   = ivl_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        dir_d   = dir_up;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    tgt_d  = target_duty;
                    step_d = step_eff;
                    ivl_d  = ivl_eff;
                    cnt_d  = ivl_eff - IVL_W'(1);
                    dir_d  = (target_duty > duty_out);
                    if (target_duty == duty_out) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                        busy_d  = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - IVL_W'(1);
                end else begin
                    duty_d = step_res;
                    cnt_d  = ivl_q - IVL_W'(1);
                    if (step_res == tgt_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_out <= '0;
            tgt_q    <= '0;
            step_q   <= '0;
            ivl_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dir_up   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_out <= duty_d;
            tgt_q    <= tgt_d;
            step_q   <= step_d;
            ivl_q    <= ivl_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            dir_up   <= dir_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp_sequencer.sv
// Self-checking bench: vector table, hand-written corner sequences and random traffic vs. a cycle-count model.
module tb_pwm_duty_ramp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [7:0]  target_duty, step_size;
    logic [15:0] step_interval;
    logic [7:0]  duty_out;
    logic        busy, done, dir_up;

    pwm_duty_ramp_sequencer #(.DUTY_W(8), .IVL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .target_duty(target_duty), .step_size(step_size), .step_interval(step_interval),
        .duty_out(duty_out), .busy(busy), .done(done), .dir_up(dir_up)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a ramp is a count of elapsed cycles; a step lands whenever that count is a multiple of the interval.
    int m_duty, m_busy, m_done, m_dir, m_t, m_s, m_iv, m_el;

    task automatic model_reset();
        m_duty = 0; m_busy = 0; m_done = 0; m_dir = 0;
        m_t = 0; m_s = 1; m_iv = 1; m_el = 0;
    endtask

    task automatic model_edge(input int s, input int a, input int t, input int st, input int iv);
        int nd;
        m_done = 0;
        if (m_busy == 0) begin
            if (s != 0 && a == 0) begin
                m_t   = t;
                m_s   = (st == 0) ? 1 : st;
                m_iv  = (iv == 0) ? 1 : iv;
                m_dir = (t > m_duty) ? 1 : 0;
                m_el  = 0;
                if (t == m_duty) m_done = 1;
                else m_busy = 1;
            end
        end else if (a != 0) begin
            m_busy = 0;
        end else begin
            m_el++;
            if (m_el % m_iv == 0) begin
                if (m_dir != 0) nd = (m_duty + m_s > m_t) ? m_t : m_duty + m_s;
                else            nd = (m_duty - m_s < m_t) ? m_t : m_duty - m_s;
                m_duty = nd;
                if (nd == m_t) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int ed, input int eb, input int edn, input int edr);
        n_checks++;
        if (int'(duty_out) != ed || int'(busy) != eb || int'(done) != edn || int'(dir_up) != edr
            || (busy && done)) begin
            n_fail++;
            $display("FAIL %s @%0t: got duty=%0d busy=%0b done=%0b dir_up=%0b, required duty=%0d busy=%0d done=%0d dir_up=%0d",
                     nm, $time, duty_out, busy, done, dir_up, ed, eb, edn, edr);
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic [7:0] t, input logic [7:0] st,
                       input logic [15:0] iv);
        start = s; abort = a; target_duty = t; step_size = st; step_interval = iv;
        @(posedge clk);
        model_edge(int'(s), int'(a), int'(t), int'(st), int'(iv));
        #1;
        chk("model", m_duty, m_busy, m_done, m_dir);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        s, a;
        logic [7:0]  t, st;
        logic [15:0] iv;
        int          ed, eb, edn, edr;
    } vec_t;

    vec_t vt[18];

    initial begin
        vt[0]  = '{1, 0,  10,  10, 1,  0, 1, 0, 1};
        vt[1]  = '{0, 0,   0,   0, 0, 10, 0, 1, 1};
        vt[2]  = '{1, 0,   0,   4, 0, 10, 1, 0, 0};
        vt[3]  = '{0, 0,   0,   0, 0,  6, 1, 0, 0};
        vt[4]  = '{0, 0,   0,   0, 0,  2, 1, 0, 0};
        vt[5]  = '{0, 0,   0,   0, 0,  0, 0, 1, 0};
        vt[6]  = '{1, 0,   0,   5, 3,  0, 0, 1, 0};
        vt[7]  = '{0, 0,   0,   0, 0,  0, 0, 0, 0};
        vt[8]  = '{1, 1,  50,   5, 1,  0, 0, 0, 0};
        vt[9]  = '{1, 0,   3,   0, 1,  0, 1, 0, 1};
        vt[10] = '{0, 0,   0,   0, 0,  1, 1, 0, 1};
        vt[11] = '{0, 0,   0,   0, 0,  2, 1, 0, 1};
        vt[12] = '{0, 0,   0,   0, 0,  3, 0, 1, 1};
        vt[13] = '{1, 0, 250, 250, 1,  3, 1, 0, 1};
        vt[14] = '{0, 0,   0,   0, 0,250, 0, 1, 1};
        vt[15] = '{1, 0, 255,  20, 1,250, 1, 0, 1};
        vt[16] = '{0, 0,   0,   0, 0,255, 0, 1, 1};
        vt[17] = '{0, 0,   0,   0, 0,255, 0, 0, 1};

        start = 0; abort = 0; target_duty = 0; step_size = 0; step_interval = 0;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_no_clk", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        chk("idle_after_reset", 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            cyc(vt[i].s, vt[i].a, vt[i].t, vt[i].st, vt[i].iv);
            chk($sformatf("vec%0d", i), vt[i].ed, vt[i].eb, vt[i].edn, vt[i].edr);
        end

        // Ramp up 0 -> 10, step 3, interval 4: steps at E0+4k.
        do_reset();
        cyc(1, 0, 8'd10, 8'd3, 16'd4);
        chk("up_e0", 0, 1, 0, 1);
        for (int k = 1; k <= 17; k++) begin
            idle(1);
            chk($sformatf("up_e%0d", k), (3 * (k / 4) > 10) ? 10 : 3 * (k / 4),
                (k < 16) ? 1 : 0, (k == 16) ? 1 : 0, 1);
        end

        // Ignored start mid-ramp, then abort holds the duty value.
        do_reset();
        cyc(1, 0, 8'd200, 8'd1, 16'd2);
        idle(5);
        cyc(1, 0, 8'd5, 8'd9, 16'd1);
        chk("start_ignored", 3, 1, 0, 1);
        idle(8);
        chk("before_abort", 7, 1, 0, 1);
        cyc(0, 1, 8'd0, 8'd0, 16'd0);
        chk("abort", 7, 0, 0, 1);
        idle(3);
        chk("after_abort", 7, 0, 0, 1);

        // Reset mid-ramp at duty 40, then ramp again from 0.
        do_reset();
        cyc(1, 0, 8'd100, 8'd1, 16'd1);
        idle(40);
        chk("pre_midreset", 40, 1, 0, 1);
        do_reset();
        cyc(1, 0, 8'd2, 8'd1, 16'd1);
        idle(2);
        chk("ramp_after_reset", 2, 0, 1, 1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 23) == 0),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 60)),
                16'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
